throughout_sched: RTL and testbench
===================================

# throughout_sched

Round-robin scheduler that shares a single burst resource between NREQ requesters. It grants one requester at a time and holds the grant for a burst of len+1 beats. The granted request must stay asserted throughout the burst; if it drops, the burst is aborted. The block sits in front of the shared datapath and is the design under test for the throughout-style request/grant assertions.

## Interface

Parameters:

- NREQ, 2, number of requesters (2..8)
- LEN_W, 4, width of each per-requester burst length field

Ports:

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; must be held until the burst ends
- len  in  NREQ*LEN_W  packed burst lengths; requester i uses len[i*LEN_W +: LEN_W]; burst = len+1 beats
- gnt  out  NREQ  one-hot grant, registered
- gnt_id  out  $clog2(NREQ)  index of the current or last grantee, registered
- beat  out  1  high on every burst cycle (equals |gnt)
- done  out  1  one-cycle pulse: burst completed normally
- abort  out  1  one-cycle pulse: burst terminated because req[gnt_id] dropped

## Operation

- FSM states: IDLE, XFER, GAP. Beat counter cnt is LEN_W bits. Round-robin pointer last is $clog2(NREQ) bits.
- Reset (sync, rst=1 at a posedge):
  - state=IDLE, gnt=0, gnt_id=0, beat=0, done=0, abort=0, cnt=0, last=NREQ-1.
  - Reset applies in any state, including mid-burst. No done or abort pulse is produced; the grant drops on the next cycle.
- IDLE:
  - If req != 0, pick the first asserted requester scanning from last+1, wrapping modulo NREQ.
  - Load gnt=onehot(winner), gnt_id=winner, last=winner, cnt=len[winner], beat=1, then go to XFER.
  - If req == 0, stay in IDLE with all outputs 0.
- XFER: checks are evaluated in this priority order at each posedge.
  1. If req[gnt_id]==0: abort=1, gnt=0, beat=0, go to GAP. This takes priority even on the final beat.
  2. Else if cnt==0: done=1, gnt=0, beat=0, go to GAP.
  3. Else: cnt=cnt-1, stay in XFER.
- GAP:
  - Lasts exactly one cycle. done/abort clear, go to IDLE. req is not sampled in GAP.
- Other requesters' req may change freely during XFER; this does not affect the current burst.
- len is sampled only at grant. Later changes to len are ignored for that burst.
- done and abort are mutually exclusive. Neither is ever high while gnt != 0.

## Timing

- Request to grant: req rising before posedge k (state IDLE) gives gnt high in cycle k+1. Latency is 1 cycle.
- An uninterrupted burst keeps gnt and beat high for exactly len+1 cycles.
- done pulses in the cycle immediately after the last beat; that cycle is the GAP cycle.
- Back-to-back bursts are separated by 2 cycles with gnt=0: the GAP cycle plus the IDLE arbitration cycle.
- Abort timing: if req[gnt_id] is low at a posedge in XFER, gnt is low and abort is high in the following cycle.
- Arbitration outcomes:
  - With all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0.
  - A single persistent requester is re-granted every burst.
- Edge values:
  - len=0 gives a 1-beat burst.
  - len=2^LEN_W-1 gives 2^LEN_W beats.
  - cnt never wraps: it is only decremented when nonzero.

## Test plan

- Reset, then a single request: NREQ=2, req=01, len0=3 → gnt=01 one cycle after sampling, for 4 cycles with beat=1; done pulses once; gnt_id=0.
- Round-robin fairness: req=11, len0=len1=1 held for 3 bursts → grant order 0,1,0; each burst lasts 2 cycles; 2 idle cycles between bursts; 3 done pulses.
- Abort mid-burst: req=01, len0=5; drop req[0] on the 3rd beat → gnt low next cycle, abort=1 for 1 cycle, done never asserts; the next grant goes to requester 1 if req[1] is set.
- Abort on last beat: len0=0; drop req[0] in the same cycle gnt rises → abort=1, done=0, demonstrating abort priority.
- Reset mid-burst: rst=1 in beat 2 of a len=7 burst → next cycle gnt=0, beat=0, done=0, abort=0; after rst deasserts with req=11, the first grant goes to requester 0 (last reset to NREQ-1).
- Max length and len stability: len0=15, with len changed to 2 during the burst → exactly 16 beats, then done.

Source files
------------

// File: rtl/throughout_sched.sv
// Round-robin scheduler granting one requester at a time a burst of len+1 beats.
// The grant is held only while the grantee keeps its request up; a dropped request aborts the burst.
module throughout_sched #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LEN_W-1:0]    len,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     beat,
  output logic                     done,
  output logic                     abort
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0]   LAST_IDX = IDW'(NREQ - 1);
  localparam logic [IDW-1:0]   ONE_ID   = IDW'(1);
  localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             beat_q, beat_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [LEN_W-1:0] len_arr_s [NREQ];
  logic [IDW-1:0]   win_s;

  // First asserted request strictly after the pointer, wrapping at NREQ-1.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  l);
    logic [IDW-1:0] c;
    logic [IDW-1:0] w;
    logic           found;
    c     = l;
    w     = l;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (c == LAST_IDX) begin
        c = {IDW{1'b0}};
      end else begin
        c = c + ONE_ID;
      end
      if (!found && r[c]) begin
        w     = c;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr_s[g] = len[g*LEN_W +: LEN_W];
  end

  // Arbitration winner for the current request vector.
  always_comb begin
    win_s = rr_pick(req, last_q);
  end

  // Next-state and registered-output values of the burst FSM.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    cnt_d    = cnt_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d  = S_XFER;
          gnt_d    = ONE_HOT0 << win_s;
          gnt_id_d = win_s;
          last_d   = win_s;
          cnt_d    = len_arr_s[win_s];
          beat_d   = 1'b1;
        end else begin
          gnt_d  = {NREQ{1'b0}};
          beat_d = 1'b0;
        end
      end
      S_XFER: begin
        // Loss of request outranks normal completion, even on the last beat.
        if (!req[gnt_id_q]) begin
          state_d = S_GAP;
          abort_d = 1'b1;
          gnt_d   = {NREQ{1'b0}};
          beat_d  = 1'b0;
        end else if (cnt_q == {LEN_W{1'b0}}) begin
          state_d = S_GAP;
          done_d  = 1'b1;
          gnt_d   = {NREQ{1'b0}};
          beat_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - ONE_LEN;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        gnt_d   = {NREQ{1'b0}};
        beat_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = {NREQ{1'b0}};
        beat_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= {NREQ{1'b0}};
      gnt_id_q <= {IDW{1'b0}};
      beat_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      cnt_q    <= {LEN_W{1'b0}};
      last_q   <= LAST_IDX;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign beat   = beat_q;
  assign done   = done_q;
  assign abort  = abort_q;

endmodule

// File: tb/tb_throughout_sched.sv
// Bench for throughout_sched: directed scenarios plus random traffic against a
// burst-level reference model (owner / beats remaining / pulse).
module tb_throughout_sched;

  localparam int NREQ  = 3;
  localparam int LEN_W = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int LW    = NREQ * LEN_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [LW-1:0]   len;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            beat, done, abort;

  always #5 clk = ~clk;

  throughout_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len),
    .gnt(gnt), .gnt_id(gnt_id), .beat(beat), .done(done), .abort(abort)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_owner = -1;   // requester holding the resource, -1 if none
  int m_left  = 0;    // beats still to be delivered including the current one
  int m_last  = NREQ - 1;
  int m_id    = 0;
  bit m_cool  = 0;    // one idle cycle owed after a burst ends
  bit m_done  = 0;
  bit m_abort = 0;

  // Observation of burst shapes
  int q_ids[$];
  int q_len[$];
  int q_gap[$];
  int n_done, n_abort, cur_beats, gap_run, bursts;
  logic [NREQ-1:0] prev_gnt;

  task automatic set_len(input int i, input int v);
    logic [LW-1:0] m;
    m   = LW'((1 << LEN_W) - 1) << (i * LEN_W);
    len = (len & ~m) | ((LW'(v) << (i * LEN_W)) & m);
  endtask

  task automatic mon_clear();
    q_ids.delete(); q_len.delete(); q_gap.delete();
    n_done = 0; n_abort = 0; cur_beats = 0; gap_run = 0; bursts = 0;
    prev_gnt = gnt;
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_cool = 0; m_done = 0; m_abort = 0; m_last = NREQ - 1; m_id = 0;
    end else if (m_owner >= 0) begin
      if (req[m_owner[IDW-1:0]] == 1'b0) begin
        m_abort = 1; m_owner = -1; m_cool = 1;
      end else if (m_left == 1) begin
        m_done = 1; m_owner = -1; m_cool = 1;
      end else begin
        m_left--;
      end
    end else if (m_cool) begin
      m_cool = 0; m_done = 0; m_abort = 0;
    end else begin
      m_done = 0; m_abort = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && req[c[IDW-1:0]]) begin
          m_owner = c; m_id = c; m_last = c;
          m_left  = int'(LEN_W'(len >> (c * LEN_W))) + 1;
        end
      end
    end
    #1;
    if (done === 1'b1) n_done++;
    if (abort === 1'b1) n_abort++;
    if (gnt != '0) begin
      if (prev_gnt == '0) begin
        if (bursts > 0) q_gap.push_back(gap_run);
        q_ids.push_back(int'(gnt_id));
        bursts++;
        cur_beats = 0;
      end
      cur_beats++;
    end else begin
      if (prev_gnt != '0) begin
        q_len.push_back(cur_beats);
        gap_run = 0;
      end
      gap_run++;
    end
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = NREQ'($urandom);
    len = LW'($urandom);
    tick();
    n_checks++;
    if ({gnt, gnt_id, beat, done, abort} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b id=%0d beat=%b done=%b abort=%b, need all 0",
               gnt, gnt_id, beat, done, abort);
    end
    rst = 1'b0; req = '0;
    tick();
    n_checks++;
    if (gnt !== '0 || beat !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: gnt=%b beat=%b, need 0 0", gnt, beat);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_len(0, 3);
    req = 3'b001;
    mon_clear();
    tick();
    n_checks++;
    if (gnt !== 3'b001 || beat !== 1'b1 || gnt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_latency: gnt=%b beat=%b id=%0d, need 001 1 0", gnt, beat, gnt_id);
    end
    for (int i = 0; i < 30 && n_done == 0; i++) tick();
    n_checks++;
    if (q_len.size() != 1 || q_len[0] != 4) begin
      n_fail++;
      $display("FAIL single_len: bursts=%0d len=%0d, need 1 burst of 4",
               q_len.size(), (q_len.size() > 0) ? q_len[0] : -1);
    end
    n_checks++;
    if (n_done != 1 || n_abort != 0) begin
      n_fail++;
      $display("FAIL single_done: done=%0d abort=%0d, need 1 0", n_done, n_abort);
    end
  endtask

  task automatic test_round_robin();
    int exp_ids[3] = '{0, 1, 0};
    do_reset();
    set_len(0, 1); set_len(1, 1);
    req = 3'b011;
    mon_clear();
    for (int i = 0; i < 60 && n_done < 3; i++) tick();
    req = '0;
    tick(); tick();
    n_checks++;
    if (q_ids.size() != 3) begin
      n_fail++;
      $display("FAIL rr_count: grants=%0d, need 3", q_ids.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (q_ids[i] != exp_ids[i] || q_len[i] != 2) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: id=%0d len=%0d, need id=%0d len=2",
                   i, q_ids[i], q_len[i], exp_ids[i]);
        end
      end
    end
    n_checks++;
    if (q_gap.size() != 2 || q_gap[0] != 2 || q_gap[1] != 2) begin
      n_fail++;
      $display("FAIL rr_gap: gaps=%0d first=%0d, need 2 gaps of 2",
               q_gap.size(), (q_gap.size() > 0) ? q_gap[0] : -1);
    end
    n_checks++;
    if (n_done != 3) begin
      n_fail++;
      $display("FAIL rr_done: done=%0d, need 3", n_done);
    end
  endtask

  task automatic test_abort_mid();
    do_reset();
    set_len(0, 5); set_len(1, 2);
    req = 3'b011;
    mon_clear();
    tick(); tick(); tick();
    n_checks++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_mid_beat3: gnt=%b, need 001", gnt);
    end
    req = 3'b010;
    tick();
    n_checks++;
    if (gnt !== '0 || abort !== 1'b1 || done !== 1'b0 || beat !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mid_pulse: gnt=%b abort=%b done=%b beat=%b, need 000 1 0 0",
               gnt, abort, done, beat);
    end
    tick();
    n_checks++;
    if (abort !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL abort_mid_gap: abort=%b gnt=%b, need 0 000", abort, gnt);
    end
    tick();
    n_checks++;
    if (gnt !== 3'b010 || gnt_id !== 2'd1 || n_done != 0) begin
      n_fail++;
      $display("FAIL abort_mid_next: gnt=%b id=%0d dones=%0d, need 010 1 0", gnt, gnt_id, n_done);
    end
  endtask

  task automatic test_abort_last();
    do_reset();
    set_len(0, 0);
    req = 3'b001;
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || abort !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL len0_done: done=%b abort=%b gnt=%b, need 1 0 000", done, abort, gnt);
    end
    do_reset();
    req = 3'b001;
    tick();
    n_checks++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_last_grant: gnt=%b, need 001", gnt);
    end
    req = '0;
    tick();
    n_checks++;
    if (abort !== 1'b1 || done !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL abort_last_prio: abort=%b done=%b gnt=%b, need 1 0 000", abort, done, gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_len(0, 7);
    req = 3'b001;
    tick(); tick();
    n_checks++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_beat2: gnt=%b, need 001", gnt);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (gnt !== '0 || beat !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: gnt=%b beat=%b done=%b abort=%b, need 000 0 0 0",
               gnt, beat, done, abort);
    end
    rst = 1'b0;
    req = 3'b011;
    tick();
    n_checks++;
    if (gnt !== 3'b001 || gnt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_ptr: gnt=%b id=%0d, need 001 0", gnt, gnt_id);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    set_len(0, 15);
    req = 3'b001;
    mon_clear();
    tick();
    set_len(0, 2);
    for (int i = 0; i < 40 && n_done == 0 && n_abort == 0; i++) tick();
    n_checks++;
    if (q_len.size() != 1 || q_len[0] != 16 || n_done != 1) begin
      n_fail++;
      $display("FAIL max_len: bursts=%0d len=%0d done=%0d, need 1 burst of 16 and 1 done",
               q_len.size(), (q_len.size() > 0) ? q_len[0] : -1, n_done);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] eg;
    int errs = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      len = LW'($urandom);
      tick();
      eg = '0;
      if (m_owner >= 0) eg = NREQ'(1) << m_owner;
      n_checks++;
      if (gnt !== eg || beat !== (m_owner >= 0) || done !== m_done || abort !== m_abort ||
          int'(gnt_id) != m_id) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: gnt=%b id=%0d beat=%b done=%b abort=%b, need %b %0d %b %b %b",
                   n, gnt, gnt_id, beat, done, abort, eg, m_id, (m_owner >= 0), m_done, m_abort);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort_mid();
    test_abort_last();
    test_reset_mid();
    test_max_len();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
